// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control-unit bundle between the instruction register, memory handshake and datapath
//
// Signals:
//   opcode_i, mem_ready_i   : opcode from IR[31:26] and the memory completion handshake (into the control unit)
//   pc_write_o ... alu_op_o : datapath control strobes and mux selects (out of the control unit)
//   state_o, illegal_op_o   : debug state encoding and sticky illegal-opcode flag
// Modports:
//   master : the control unit (drives the control outputs)
//   slave  : the datapath / environment (drives opcode and mem_ready)

interface multicycle_control_if #(
    parameter int ALU_OP_WIDTH = 3
);
    logic [5:0]              opcode_i;
    logic                    mem_ready_i;
    logic                    pc_write_o;
    logic                    pc_write_cond_eq_o;
    logic                    pc_write_cond_ne_o;
    logic                    i_or_d_o;
    logic                    mem_read_o;
    logic                    mem_write_o;
    logic                    ir_write_o;
    logic [1:0]              reg_dst_o;
    logic [1:0]              mem_to_reg_o;
    logic                    reg_write_o;
    logic                    alu_src_a_o;
    logic [1:0]              alu_src_b_o;
    logic [1:0]              pc_src_o;
    logic [ALU_OP_WIDTH-1:0] alu_op_o;
    logic [3:0]              state_o;
    logic                    illegal_op_o;

    modport master (
        input  opcode_i, mem_ready_i,
        output pc_write_o, pc_write_cond_eq_o, pc_write_cond_ne_o, i_or_d_o,
               mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
               reg_write_o, alu_src_a_o, alu_src_b_o, pc_src_o, alu_op_o,
               state_o, illegal_op_o
    );

    modport slave (
        output opcode_i, mem_ready_i,
        input  pc_write_o, pc_write_cond_eq_o, pc_write_cond_ne_o, i_or_d_o,
               mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
               reg_write_o, alu_src_a_o, alu_src_b_o, pc_src_o, alu_op_o,
               state_o, illegal_op_o
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main control FSM with memory-ready stall and illegal-opcode trap
//
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous active-low reset; while low every output is forced to 0
//   bus   : multicycle_control_if.master (opcode/mem_ready in, datapath controls out)
// Parameters:
//   ALU_OP_WIDTH  : width of alu_op_o (3-bit codes zero-extended)
//   MEM_HANDSHAKE : 1 = memory states stall on mem_ready_i, 0 = memory always ready

module multicycle_control #(
    parameter int ALU_OP_WIDTH  = 3,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_ANDI = 3'b010;
    localparam logic [2:0] ALU_ADDI = 3'b100;
    localparam logic [2:0] ALU_ORI  = 3'b101;
    localparam logic [2:0] ALU_LUI  = 3'b110;
    localparam logic [2:0] ALU_FUNC = 3'b111;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   mem_ready;

    assign mem_ready = MEM_HANDSHAKE ? bus.mem_ready_i : 1'b1;

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (bus.opcode_i)
                    OP_LW, OP_SW:                    state_d = S_MEM_ADDR;
                    OP_R:                            state_d = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_EXEC_I;
                    OP_BEQ, OP_BNE:                  state_d = S_BRANCH;
                    OP_J, OP_JAL:                    state_d = S_JUMP;
                    default:                         state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                // Opcode is held stable by the IR, so only LW/SW can reach here
                if (bus.opcode_i == OP_SW) state_d = S_MEM_WR;
                else                       state_d = S_MEM_RD;
            end
            S_MEM_RD: begin
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB:  state_d = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R:  state_d = S_ALU_WB;
            S_EXEC_I:  state_d = S_ALU_WB;
            S_ALU_WB:  state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_FETCH;
        endcase
        if (state_d == S_ILLEGAL) illegal_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Output decode: combinational from state and opcode; the whole block is
    // gated by reset so no strobe can leak out during a reset cycle.
    logic       pc_write, cond_eq, cond_ne, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_write, src_a;
    logic [1:0] reg_dst, mem_to_reg, src_b, pc_src;
    logic [2:0] alu_code;

    always_comb begin
        pc_write   = 1'b0;
        cond_eq    = 1'b0;
        cond_ne    = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        src_a      = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        src_b      = 2'b00;
        pc_src     = 2'b00;
        alu_code   = ALU_ADD;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    src_b    = 2'b01;
                    // IR and PC load only on the completing cycle of the fetch
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_DECODE: begin
                    src_b = 2'b11;
                end
                S_MEM_ADDR: begin
                    src_a = 1'b1;
                    src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXEC_R: begin
                    src_a    = 1'b1;
                    alu_code = ALU_FUNC;
                end
                S_EXEC_I: begin
                    src_a = 1'b1;
                    src_b = 2'b10;
                    case (bus.opcode_i)
                        OP_ADDI: alu_code = ALU_ADDI;
                        OP_ANDI: alu_code = ALU_ANDI;
                        OP_ORI:  alu_code = ALU_ORI;
                        OP_LUI:  alu_code = ALU_LUI;
                        default: alu_code = ALU_ADD;
                    endcase
                end
                S_ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = (bus.opcode_i == OP_R) ? 2'b01 : 2'b00;
                end
                S_BRANCH: begin
                    src_a    = 1'b1;
                    pc_src   = 2'b01;
                    alu_code = ALU_SUB;
                    cond_eq  = (bus.opcode_i == OP_BEQ);
                    cond_ne  = (bus.opcode_i == OP_BNE);
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                    if (bus.opcode_i == OP_JAL) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_write_o         = pc_write;
    assign bus.pc_write_cond_eq_o = cond_eq;
    assign bus.pc_write_cond_ne_o = cond_ne;
    assign bus.i_or_d_o           = i_or_d;
    assign bus.mem_read_o         = mem_read;
    assign bus.mem_write_o        = mem_write;
    assign bus.ir_write_o         = ir_write;
    assign bus.reg_dst_o          = reg_dst;
    assign bus.mem_to_reg_o       = mem_to_reg;
    assign bus.reg_write_o        = reg_write;
    assign bus.alu_src_a_o        = src_a;
    assign bus.alu_src_b_o        = src_b;
    assign bus.pc_src_o           = pc_src;
    assign bus.alu_op_o           = ALU_OP_WIDTH'(alu_code);
    assign bus.state_o            = reset ? state_q : 4'd0;
    assign bus.illegal_op_o       = reset & illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control with directed instruction sequences

module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, ceq, cne, iord, mrd, mwr, irw;
        logic [1:0] rdst, m2r;
        logic       rw, sa;
        logic [1:0] sb, ps;
        logic [2:0] alu;
        logic       ill;
    } out_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    out_t  exp_q[$];
    string name_q[$];
    out_t  mon_a, mon_e;
    string mon_n;

    multicycle_control_if #(.ALU_OP_WIDTH(3)) bus();

    multicycle_control #(
        .ALU_OP_WIDTH (3),
        .MEM_HANDSHAKE(1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vectors per state, written from the state table
    function automatic out_t o_zero();
        out_t o;
        o = '0;
        return o;
    endfunction

    function automatic out_t o_fetch(input logic rdy);
        out_t o = '0;
        o.st = 4'd0; o.mrd = 1'b1; o.sb = 2'b01; o.pcw = rdy; o.irw = rdy;
        return o;
    endfunction

    function automatic out_t o_decode();
        out_t o = '0;
        o.st = 4'd1; o.sb = 2'b11;
        return o;
    endfunction

    function automatic out_t o_maddr();
        out_t o = '0;
        o.st = 4'd2; o.sa = 1'b1; o.sb = 2'b10;
        return o;
    endfunction

    function automatic out_t o_mrd();
        out_t o = '0;
        o.st = 4'd3; o.mrd = 1'b1; o.iord = 1'b1;
        return o;
    endfunction

    function automatic out_t o_mwb();
        out_t o = '0;
        o.st = 4'd4; o.rw = 1'b1; o.m2r = 2'b01;
        return o;
    endfunction

    function automatic out_t o_mwr();
        out_t o = '0;
        o.st = 4'd5; o.mwr = 1'b1; o.iord = 1'b1;
        return o;
    endfunction

    function automatic out_t o_exec_r();
        out_t o = '0;
        o.st = 4'd6; o.sa = 1'b1; o.alu = 3'b111;
        return o;
    endfunction

    function automatic out_t o_exec_i(input logic [2:0] alu);
        out_t o = '0;
        o.st = 4'd7; o.sa = 1'b1; o.sb = 2'b10; o.alu = alu;
        return o;
    endfunction

    function automatic out_t o_alu_wb(input logic [1:0] rdst);
        out_t o = '0;
        o.st = 4'd8; o.rw = 1'b1; o.rdst = rdst;
        return o;
    endfunction

    function automatic out_t o_branch(input logic eq, input logic ne);
        out_t o = '0;
        o.st = 4'd9; o.sa = 1'b1; o.ps = 2'b01; o.alu = 3'b001; o.ceq = eq; o.cne = ne;
        return o;
    endfunction

    function automatic out_t o_jump(input logic jal);
        out_t o = '0;
        o.st = 4'd10; o.pcw = 1'b1; o.ps = 2'b10;
        if (jal) begin
            o.rw = 1'b1; o.rdst = 2'b10; o.m2r = 2'b10;
        end
        return o;
    endfunction

    function automatic out_t o_illegal();
        out_t o = '0;
        o.st = 4'd11; o.ill = 1'b1;
        return o;
    endfunction

    // One clock cycle of stimulus: drive inputs just after the edge and
    // queue the response expected for that cycle.
    task automatic cyc(input logic rst, input logic [5:0] op, input logic rdy,
                       input string nm, input out_t e);
        @(posedge clk);
        #1;
        reset          = rst;
        bus.opcode_i   = op;
        bus.mem_ready_i = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compares every presented cycle against the scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            mon_a.st   = bus.state_o;
            mon_a.pcw  = bus.pc_write_o;
            mon_a.ceq  = bus.pc_write_cond_eq_o;
            mon_a.cne  = bus.pc_write_cond_ne_o;
            mon_a.iord = bus.i_or_d_o;
            mon_a.mrd  = bus.mem_read_o;
            mon_a.mwr  = bus.mem_write_o;
            mon_a.irw  = bus.ir_write_o;
            mon_a.rdst = bus.reg_dst_o;
            mon_a.m2r  = bus.mem_to_reg_o;
            mon_a.rw   = bus.reg_write_o;
            mon_a.sa   = bus.alu_src_a_o;
            mon_a.sb   = bus.alu_src_b_o;
            mon_a.ps   = bus.pc_src_o;
            mon_a.alu  = bus.alu_op_o;
            mon_a.ill  = bus.illegal_op_o;
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL %s: got %h expected %h (state got %0d expected %0d)",
                         mon_n, mon_a, mon_e, mon_a.st, mon_e.st);
            end
        end
    end

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b0;
        bus.opcode_i    = 6'h00;
        bus.mem_ready_i = 1'b0;

        // Reset state
        cyc(1'b0, 6'h00, 1'b0, "reset0", o_zero());
        cyc(1'b0, 6'h00, 1'b1, "reset1", o_zero());

        // ADDI, ready tied high: 0,1,7,8
        cyc(1'b1, 6'h08, 1'b1, "addi_fetch",  o_fetch(1'b1));
        cyc(1'b1, 6'h08, 1'b1, "addi_decode", o_decode());
        cyc(1'b1, 6'h08, 1'b1, "addi_exec",   o_exec_i(3'b100));
        cyc(1'b1, 6'h08, 1'b1, "addi_wb",     o_alu_wb(2'b00));

        // LW with two wait cycles in MEM_RD: 0,1,2,3,3,3,4
        cyc(1'b1, 6'h23, 1'b1, "lw_fetch",  o_fetch(1'b1));
        cyc(1'b1, 6'h23, 1'b1, "lw_decode", o_decode());
        cyc(1'b1, 6'h23, 1'b1, "lw_addr",   o_maddr());
        cyc(1'b1, 6'h23, 1'b0, "lw_rd_w1",  o_mrd());
        cyc(1'b1, 6'h23, 1'b0, "lw_rd_w2",  o_mrd());
        cyc(1'b1, 6'h23, 1'b1, "lw_rd",     o_mrd());
        cyc(1'b1, 6'h23, 1'b1, "lw_wb",     o_mwb());

        // BNE: 3 cycles
        cyc(1'b1, 6'h05, 1'b1, "bne_fetch",  o_fetch(1'b1));
        cyc(1'b1, 6'h05, 1'b1, "bne_decode", o_decode());
        cyc(1'b1, 6'h05, 1'b1, "bne_branch", o_branch(1'b0, 1'b1));

        // JAL: 3 cycles
        cyc(1'b1, 6'h03, 1'b1, "jal_fetch",  o_fetch(1'b1));
        cyc(1'b1, 6'h03, 1'b1, "jal_decode", o_decode());
        cyc(1'b1, 6'h03, 1'b1, "jal_jump",   o_jump(1'b1));

        // SW with a fetch wait and a write wait
        cyc(1'b1, 6'h2B, 1'b0, "sw_fetch_w", o_fetch(1'b0));
        cyc(1'b1, 6'h2B, 1'b1, "sw_fetch",   o_fetch(1'b1));
        cyc(1'b1, 6'h2B, 1'b1, "sw_decode",  o_decode());
        cyc(1'b1, 6'h2B, 1'b1, "sw_addr",    o_maddr());
        cyc(1'b1, 6'h2B, 1'b0, "sw_wr_w",    o_mwr());
        cyc(1'b1, 6'h2B, 1'b1, "sw_wr",      o_mwr());

        // R-type: reg_dst = rd
        cyc(1'b1, 6'h00, 1'b1, "r_fetch",  o_fetch(1'b1));
        cyc(1'b1, 6'h00, 1'b1, "r_decode", o_decode());
        cyc(1'b1, 6'h00, 1'b1, "r_exec",   o_exec_r());
        cyc(1'b1, 6'h00, 1'b1, "r_wb",     o_alu_wb(2'b01));

        // ORI, ANDI, LUI ALU codes
        cyc(1'b1, 6'h0D, 1'b1, "ori_fetch",  o_fetch(1'b1));
        cyc(1'b1, 6'h0D, 1'b1, "ori_decode", o_decode());
        cyc(1'b1, 6'h0D, 1'b1, "ori_exec",   o_exec_i(3'b101));
        cyc(1'b1, 6'h0D, 1'b1, "ori_wb",     o_alu_wb(2'b00));
        cyc(1'b1, 6'h0C, 1'b1, "andi_fetch",  o_fetch(1'b1));
        cyc(1'b1, 6'h0C, 1'b1, "andi_decode", o_decode());
        cyc(1'b1, 6'h0C, 1'b1, "andi_exec",   o_exec_i(3'b010));
        cyc(1'b1, 6'h0C, 1'b1, "andi_wb",     o_alu_wb(2'b00));
        cyc(1'b1, 6'h0F, 1'b1, "lui_fetch",  o_fetch(1'b1));
        cyc(1'b1, 6'h0F, 1'b1, "lui_decode", o_decode());
        cyc(1'b1, 6'h0F, 1'b1, "lui_exec",   o_exec_i(3'b110));
        cyc(1'b1, 6'h0F, 1'b1, "lui_wb",     o_alu_wb(2'b00));

        // BEQ and plain J
        cyc(1'b1, 6'h04, 1'b1, "beq_fetch",  o_fetch(1'b1));
        cyc(1'b1, 6'h04, 1'b1, "beq_decode", o_decode());
        cyc(1'b1, 6'h04, 1'b1, "beq_branch", o_branch(1'b1, 1'b0));
        cyc(1'b1, 6'h02, 1'b1, "j_fetch",  o_fetch(1'b1));
        cyc(1'b1, 6'h02, 1'b1, "j_decode", o_decode());
        cyc(1'b1, 6'h02, 1'b1, "j_jump",   o_jump(1'b0));

        // Reset held low 3 cycles during a MEM_RD wait
        cyc(1'b1, 6'h23, 1'b1, "lwr_fetch",  o_fetch(1'b1));
        cyc(1'b1, 6'h23, 1'b1, "lwr_decode", o_decode());
        cyc(1'b1, 6'h23, 1'b1, "lwr_addr",   o_maddr());
        cyc(1'b1, 6'h23, 1'b0, "lwr_rd_w",   o_mrd());
        cyc(1'b0, 6'h23, 1'b1, "midrst0", o_zero());
        cyc(1'b0, 6'h23, 1'b1, "midrst1", o_zero());
        cyc(1'b0, 6'h23, 1'b1, "midrst2", o_zero());
        cyc(1'b1, 6'h23, 1'b0, "post_rst_fetch", o_fetch(1'b0));
        cyc(1'b1, 6'h23, 1'b1, "post_rst_fetch_rdy", o_fetch(1'b1));
        cyc(1'b1, 6'h23, 1'b1, "post_rst_decode", o_decode());
        cyc(1'b1, 6'h23, 1'b1, "post_rst_addr",   o_maddr());
        cyc(1'b1, 6'h23, 1'b1, "post_rst_rd",     o_mrd());
        cyc(1'b1, 6'h23, 1'b1, "post_rst_wb",     o_mwb());

        // Illegal opcode: terminal, sticky, no strobes
        cyc(1'b1, 6'h3F, 1'b1, "ill_fetch",  o_fetch(1'b1));
        cyc(1'b1, 6'h3F, 1'b1, "ill_decode", o_decode());
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, (i < 6) ? 6'h3F : 6'h08, i[0], "ill_hold", o_illegal());
        end
        cyc(1'b0, 6'h08, 1'b1, "ill_reset",   o_zero());
        cyc(1'b1, 6'h08, 1'b1, "ill_cleared", o_fetch(1'b1));
        cyc(1'b1, 6'h08, 1'b1, "ill_next_decode", o_decode());

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
